// File: rtl/pcie_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : pcie_tx_arbiter_if
// Description : 32-bit AXI-stream beat bundle used on both sides of the
//               PCIe TX arbiter (requester inputs and core-facing output).
// Revision    : 1.0 - initial release
// ============================================================================
interface pcie_tx_arbiter_if;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic [3:0]  tuser;
    logic        tlast;
    logic        tvalid;
    logic        tready;

    // Source of a stream: drives the beat, receives backpressure
    modport master (
        output tdata,
        output tkeep,
        output tuser,
        output tlast,
        output tvalid,
        input  tready
    );

    // Sink of a stream: receives the beat, drives backpressure
    modport slave (
        input  tdata,
        input  tkeep,
        input  tuser,
        input  tlast,
        input  tvalid,
        output tready
    );
endinterface
`default_nettype wire

// File: rtl/pcie_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pcie_tx_arbiter
// Description : Packet-granular round-robin arbiter sharing the PCIe core TX
//               stream between the control (port 0) and data (port 1)
//               functions. Services config-transmit requests, gates packet
//               starts on TX buffer availability, drains in-flight packets on
//               link loss and keeps a saturating count of core TX drops.
// Revision    : 1.0 - initial release
// ============================================================================
module pcie_tx_arbiter #(
    parameter int MIN_BUF_AV     = 2,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  wire logic                      clk,
    input  wire logic                      rst,
    input  wire logic                      i_user_lnk_up,
    pcie_tx_arbiter_if.slave               i_s0,
    pcie_tx_arbiter_if.slave               i_s1,
    pcie_tx_arbiter_if.master              o_tx,
    input  wire logic [5:0]                i_tx_buf_av,
    input  wire logic                      i_tx_cfg_req,
    output logic                           o_tx_cfg_gnt,
    input  wire logic                      i_tx_err_drop,
    output logic [DROP_CNT_WIDTH-1:0]      o_drop_count,
    output logic [1:0]                     o_active,
    output logic                           o_busy
);

    localparam logic [5:0] C_MIN_BUF_AV = 6'(MIN_BUF_AV);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PKT   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_CFG   = 2'd3
    } state_t;

    state_t                    r_state;
    state_t                    w_next_state;
    logic                      r_owner;        // 0 = port 0, 1 = port 1
    logic                      w_next_owner;
    logic                      r_last_grant;
    logic                      w_next_last_grant;
    logic                      r_cfg_gnt;
    logic [DROP_CNT_WIDTH-1:0] r_drop_count;

    logic                      w_own_valid;
    logic                      w_own_last;
    logic                      w_winner;

    assign w_own_valid = r_owner ? i_s1.tvalid : i_s0.tvalid;
    assign w_own_last  = r_owner ? i_s1.tlast  : i_s0.tlast;
    // Both requesting: the port that did not win last time; otherwise the lone requester
    assign w_winner    = (i_s0.tvalid && i_s1.tvalid) ? ~r_last_grant : i_s1.tvalid;

    // Next-state, ownership and round-robin pointer decisions
    always_comb begin
        w_next_state      = r_state;
        w_next_owner      = r_owner;
        w_next_last_grant = r_last_grant;
        case (r_state)
            ST_IDLE: begin
                if (i_user_lnk_up) begin
                    if (i_tx_cfg_req) begin
                        w_next_state = ST_CFG;
                    end else if ((i_s0.tvalid || i_s1.tvalid) && (i_tx_buf_av >= C_MIN_BUF_AV)) begin
                        w_next_state      = ST_PKT;
                        w_next_owner      = w_winner;
                        w_next_last_grant = w_winner;
                    end
                end
            end
            ST_PKT: begin
                // A completing tlast beat wins over a simultaneous link drop
                if (w_own_valid && o_tx.tready && w_own_last) begin
                    w_next_state = ST_IDLE;
                end else if (!i_user_lnk_up) begin
                    w_next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_own_valid && w_own_last) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_CFG: begin
                if (!i_tx_cfg_req || !i_user_lnk_up) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State, owner, round-robin pointer and registered config grant
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_cfg_gnt    <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_owner      <= w_next_owner;
            r_last_grant <= w_next_last_grant;
            r_cfg_gnt    <= (w_next_state == ST_CFG);
        end
    end

    // Zero-latency datapath mux; DRAIN swallows owner beats with tvalid held low
    always_comb begin
        o_tx.tdata  = '0;
        o_tx.tkeep  = '0;
        o_tx.tuser  = '0;
        o_tx.tlast  = 1'b0;
        o_tx.tvalid = 1'b0;
        i_s0.tready = 1'b0;
        i_s1.tready = 1'b0;
        if (r_state == ST_PKT) begin
            if (r_owner) begin
                o_tx.tdata  = i_s1.tdata;
                o_tx.tkeep  = i_s1.tkeep;
                o_tx.tuser  = i_s1.tuser;
                o_tx.tlast  = i_s1.tlast;
                o_tx.tvalid = i_s1.tvalid;
                i_s1.tready = o_tx.tready;
            end else begin
                o_tx.tdata  = i_s0.tdata;
                o_tx.tkeep  = i_s0.tkeep;
                o_tx.tuser  = i_s0.tuser;
                o_tx.tlast  = i_s0.tlast;
                o_tx.tvalid = i_s0.tvalid;
                i_s0.tready = o_tx.tready;
            end
        end else if (r_state == ST_DRAIN) begin
            if (r_owner) begin
                i_s1.tready = 1'b1;
            end else begin
                i_s0.tready = 1'b1;
            end
        end
    end

    // Saturating count of core-reported TX drops
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_count <= '0;
        end else if (i_tx_err_drop && !(&r_drop_count)) begin
            r_drop_count <= r_drop_count + 1'b1;
        end
    end

    assign o_tx_cfg_gnt = r_cfg_gnt;
    assign o_drop_count = r_drop_count;
    assign o_busy       = (r_state != ST_IDLE);
    assign o_active     = ((r_state == ST_PKT) || (r_state == ST_DRAIN)) ?
                          (r_owner ? 2'b10 : 2'b01) : 2'b00;

endmodule
`default_nettype wire

// File: tb/tb_pcie_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pcie_tx_arbiter
// Description : Directed self-checking bench for pcie_tx_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pcie_tx_arbiter;

    logic        clk;
    logic        rst;
    logic        lnk_up;
    logic [5:0]  buf_av;
    logic        cfg_req;
    logic        cfg_gnt;
    logic        err_drop;
    logic [15:0] drop_count;
    logic [1:0]  active;
    logic        busy;

    pcie_tx_arbiter_if s0_bus ();
    pcie_tx_arbiter_if s1_bus ();
    pcie_tx_arbiter_if tx_bus ();

    pcie_tx_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .i_user_lnk_up (lnk_up),
        .i_s0          (s0_bus),
        .i_s1          (s1_bus),
        .o_tx          (tx_bus),
        .i_tx_buf_av   (buf_av),
        .i_tx_cfg_req  (cfg_req),
        .o_tx_cfg_gnt  (cfg_gnt),
        .i_tx_err_drop (err_drop),
        .o_drop_count  (drop_count),
        .o_active      (active),
        .o_busy        (busy)
    );

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;

    // Requester queues: bit 32 = tlast, bits 31:0 = tdata (tuser mirrors tdata[3:0])
    logic [32:0] q0[$];
    logic [32:0] q1[$];
    logic        hs0 = 1'b0;
    logic        hs1 = 1'b0;

    // Log of beats delivered to the core
    logic [31:0] log_data[$];
    logic        log_last[$];
    logic [1:0]  log_act[$];
    logic [3:0]  log_user[$];
    int          log_cyc[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        hs0 = s0_bus.tvalid & s0_bus.tready;
        hs1 = s1_bus.tvalid & s1_bus.tready;
        if (tx_bus.tvalid && tx_bus.tready) begin
            log_data.push_back(tx_bus.tdata);
            log_last.push_back(tx_bus.tlast);
            log_act.push_back(active);
            log_user.push_back(tx_bus.tuser);
            log_cyc.push_back(cyc);
        end
    end

    // Port 0 requester: holds the head beat until it is accepted
    initial begin
        s0_bus.tvalid = 1'b0; s0_bus.tdata = '0; s0_bus.tlast = 1'b0;
        s0_bus.tuser = '0; s0_bus.tkeep = 4'hF;
        forever begin
            @(posedge clk); #1;
            if (hs0 && q0.size() > 0) q0.delete(0);
            if (q0.size() > 0) begin
                s0_bus.tvalid = 1'b1; s0_bus.tdata = q0[0][31:0];
                s0_bus.tlast = q0[0][32]; s0_bus.tuser = q0[0][3:0];
            end else begin
                s0_bus.tvalid = 1'b0; s0_bus.tdata = '0; s0_bus.tlast = 1'b0; s0_bus.tuser = '0;
            end
        end
    end

    // Port 1 requester
    initial begin
        s1_bus.tvalid = 1'b0; s1_bus.tdata = '0; s1_bus.tlast = 1'b0;
        s1_bus.tuser = '0; s1_bus.tkeep = 4'hF;
        forever begin
            @(posedge clk); #1;
            if (hs1 && q1.size() > 0) q1.delete(0);
            if (q1.size() > 0) begin
                s1_bus.tvalid = 1'b1; s1_bus.tdata = q1[0][31:0];
                s1_bus.tlast = q1[0][32]; s1_bus.tuser = q1[0][3:0];
            end else begin
                s1_bus.tvalid = 1'b0; s1_bus.tdata = '0; s1_bus.tlast = 1'b0; s1_bus.tuser = '0;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #3;
    endtask

    task automatic clear_log();
        log_data.delete(); log_last.delete(); log_act.delete();
        log_user.delete(); log_cyc.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else pass_cnt++;
        total_cnt++; if (active !== 2'b00) $display("FAIL reset_active got %b exp 00", active); else pass_cnt++;
        total_cnt++; if (tx_bus.tvalid !== 1'b0) $display("FAIL reset_tvalid got %b exp 0", tx_bus.tvalid); else pass_cnt++;
        total_cnt++; if (tx_bus.tdata !== 32'h0) $display("FAIL reset_tdata got %h exp 0", tx_bus.tdata); else pass_cnt++;
        total_cnt++; if (s0_bus.tready !== 1'b0) $display("FAIL reset_s0_tready got %b exp 0", s0_bus.tready); else pass_cnt++;
        total_cnt++; if (s1_bus.tready !== 1'b0) $display("FAIL reset_s1_tready got %b exp 0", s1_bus.tready); else pass_cnt++;
        total_cnt++; if (cfg_gnt !== 1'b0) $display("FAIL reset_cfg_gnt got %b exp 0", cfg_gnt); else pass_cnt++;
        total_cnt++; if (drop_count !== 16'h0) $display("FAIL reset_drop got %h exp 0", drop_count); else pass_cnt++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_port();
        clear_log();
        for (int i = 1; i <= 4; i++) q0.push_back({(i == 4), 32'(i)});
        for (int t = 0; t < 20 && log_data.size() < 4; t++) tick();
        total_cnt++;
        if (log_data.size() != 4) begin
            $display("FAIL single_timeout got %0d beats exp 4", log_data.size());
        end else begin
            pass_cnt++;
            for (int i = 0; i < 4; i++) begin
                total_cnt++; if (log_data[i] !== 32'(i + 1)) $display("FAIL single_data%0d got %h exp %h", i, log_data[i], i + 1); else pass_cnt++;
                total_cnt++; if (log_last[i] !== (i == 3)) $display("FAIL single_last%0d got %b exp %b", i, log_last[i], (i == 3)); else pass_cnt++;
                total_cnt++; if (log_act[i] !== 2'b01) $display("FAIL single_active%0d got %b exp 01", i, log_act[i]); else pass_cnt++;
                total_cnt++; if (log_user[i] !== 4'(i + 1)) $display("FAIL single_tuser%0d got %h exp %h", i, log_user[i], i + 1); else pass_cnt++;
                if (i > 0) begin
                    total_cnt++; if (log_cyc[i] - log_cyc[i-1] != 1) $display("FAIL single_gap%0d got %0d exp 1", i, log_cyc[i] - log_cyc[i-1]); else pass_cnt++;
                end
            end
        end
        total_cnt++; if (busy !== 1'b0) $display("FAIL single_idle_busy got %b exp 0", busy); else pass_cnt++;
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_data [8];
        logic [1:0]  exp_act [8];
        exp_data = '{32'hA0, 32'hA1, 32'hB0, 32'hB1, 32'hA2, 32'hA3, 32'hB2, 32'hB3};
        exp_act  = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10};
        rst = 1'b1; tick(); rst = 1'b0;
        clear_log();
        q0.push_back({1'b0, 32'hA0}); q0.push_back({1'b1, 32'hA1});
        q0.push_back({1'b0, 32'hA2}); q0.push_back({1'b1, 32'hA3});
        q1.push_back({1'b0, 32'hB0}); q1.push_back({1'b1, 32'hB1});
        q1.push_back({1'b0, 32'hB2}); q1.push_back({1'b1, 32'hB3});
        for (int t = 0; t < 40 && log_data.size() < 8; t++) tick();
        total_cnt++;
        if (log_data.size() != 8) begin
            $display("FAIL rr_timeout got %0d beats exp 8", log_data.size());
        end else begin
            pass_cnt++;
            for (int i = 0; i < 8; i++) begin
                total_cnt++; if (log_data[i] !== exp_data[i]) $display("FAIL rr_data%0d got %h exp %h", i, log_data[i], exp_data[i]); else pass_cnt++;
                total_cnt++; if (log_act[i] !== exp_act[i]) $display("FAIL rr_active%0d got %b exp %b", i, log_act[i], exp_act[i]); else pass_cnt++;
                if (i > 0) begin
                    total_cnt++;
                    if (log_cyc[i] - log_cyc[i-1] != ((i % 2 == 0) ? 2 : 1))
                        $display("FAIL rr_gap%0d got %0d exp %0d", i, log_cyc[i] - log_cyc[i-1], (i % 2 == 0) ? 2 : 1);
                    else pass_cnt++;
                end
            end
        end
        tick();
    endtask

    task automatic test_cfg();
        int t_last;
        int t_gnt;
        int t_drop;
        bit seen;
        clear_log();
        for (int i = 0; i < 4; i++) q1.push_back({(i == 3), 32'hC0 + 32'(i)});
        seen = 0;
        for (int t = 0; t < 20 && !seen; t++) begin
            tick();
            if (tx_bus.tvalid && tx_bus.tdata == 32'hC1) seen = 1;
        end
        total_cnt++; if (!seen) $display("FAIL cfg_beat2_timeout got 0 exp 1"); else pass_cnt++;
        cfg_req = 1'b1;
        q0.push_back({1'b0, 32'hD0}); q0.push_back({1'b1, 32'hD1});
        t_gnt = -1;
        for (int t = 0; t < 20 && t_gnt < 0; t++) begin
            tick();
            if (cfg_gnt === 1'b1) t_gnt = cyc;
        end
        t_last = -1;
        for (int i = 0; i < log_data.size(); i++) if (log_data[i] == 32'hC3) t_last = log_cyc[i];
        total_cnt++; if (log_data.size() != 4) $display("FAIL cfg_s1_beats got %0d exp 4", log_data.size()); else pass_cnt++;
        total_cnt++; if (t_gnt - t_last != 2) $display("FAIL cfg_gnt_rise got %0d exp 2", t_gnt - t_last); else pass_cnt++;
        tick(); tick();
        total_cnt++; if (cfg_gnt !== 1'b1) $display("FAIL cfg_gnt_hold got %b exp 1", cfg_gnt); else pass_cnt++;
        total_cnt++; if (tx_bus.tvalid !== 1'b0) $display("FAIL cfg_tvalid got %b exp 0", tx_bus.tvalid); else pass_cnt++;
        cfg_req = 1'b0;
        t_drop = cyc;
        tick();
        total_cnt++; if (cfg_gnt !== 1'b0) $display("FAIL cfg_gnt_fall got %b exp 0 (cycle %0d after drop)", cfg_gnt, cyc - t_drop); else pass_cnt++;
        tick();
        total_cnt++; if (tx_bus.tvalid !== 1'b1 || tx_bus.tdata !== 32'hD0) $display("FAIL cfg_s0_after got %b/%h exp 1/000000d0", tx_bus.tvalid, tx_bus.tdata); else pass_cnt++;
        total_cnt++; if (active !== 2'b01) $display("FAIL cfg_s0_active got %b exp 01", active); else pass_cnt++;
        for (int t = 0; t < 10 && q0.size() > 0; t++) tick();
        tick();
    endtask

    task automatic test_buf_av();
        clear_log();
        buf_av = 6'd1;
        q0.push_back({1'b0, 32'hE0}); q0.push_back({1'b1, 32'hE1});
        for (int t = 0; t < 4; t++) begin
            tick();
            total_cnt++; if (tx_bus.tvalid !== 1'b0 || busy !== 1'b0) $display("FAIL bufav_hold%0d got tvalid=%b busy=%b exp 0/0", t, tx_bus.tvalid, busy); else pass_cnt++;
        end
        buf_av = 6'd2;
        tick();
        total_cnt++; if (tx_bus.tvalid !== 1'b1 || tx_bus.tdata !== 32'hE0) $display("FAIL bufav_grant got %b/%h exp 1/000000e0", tx_bus.tvalid, tx_bus.tdata); else pass_cnt++;
        total_cnt++; if (active !== 2'b01) $display("FAIL bufav_active got %b exp 01", active); else pass_cnt++;
        for (int t = 0; t < 10 && q0.size() > 0; t++) tick();
        buf_av = 6'd8;
        tick();
    endtask

    task automatic test_link_drop();
        bit seen;
        clear_log();
        for (int i = 0; i < 8; i++) q0.push_back({(i == 7), 32'hF0 + 32'(i)});
        seen = 0;
        for (int t = 0; t < 20 && !seen; t++) begin
            tick();
            if (tx_bus.tvalid && tx_bus.tdata == 32'hF1) seen = 1;
        end
        total_cnt++; if (!seen) $display("FAIL drop_beat2_timeout got 0 exp 1"); else pass_cnt++;
        lnk_up = 1'b0;
        q1.push_back({1'b1, 32'h6000});
        for (int t = 0; t < 20 && q0.size() > 0; t++) begin
            tick();
            if (q0.size() > 0) begin
                total_cnt++;
                if (tx_bus.tvalid !== 1'b0 || s0_bus.tready !== 1'b1 || s1_bus.tready !== 1'b0 || active !== 2'b01)
                    $display("FAIL drain_cyc%0d got tvalid=%b s0rdy=%b s1rdy=%b act=%b exp 0/1/0/01", t, tx_bus.tvalid, s0_bus.tready, s1_bus.tready, active);
                else pass_cnt++;
            end
        end
        total_cnt++; if (q0.size() != 0) $display("FAIL drain_timeout got %0d left exp 0", q0.size()); else pass_cnt++;
        total_cnt++; if (log_data.size() != 2) $display("FAIL drain_logged got %0d exp 2", log_data.size()); else pass_cnt++;
        for (int t = 0; t < 3; t++) begin
            tick();
            total_cnt++; if (busy !== 1'b0 || s1_bus.tready !== 1'b0) $display("FAIL linkdown_idle%0d got busy=%b s1rdy=%b exp 0/0", t, busy, s1_bus.tready); else pass_cnt++;
        end
        lnk_up = 1'b1;
        for (int t = 0; t < 10 && log_data.size() < 3; t++) tick();
        total_cnt++;
        if (log_data.size() != 3) $display("FAIL relink_timeout got %0d exp 3", log_data.size());
        else if (log_data[2] !== 32'h6000 || log_act[2] !== 2'b10) $display("FAIL relink_beat got %h/%b exp 00006000/10", log_data[2], log_act[2]);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_drop_counter();
        err_drop = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        total_cnt++; if (drop_count !== 16'd3) $display("FAIL drop_three got %h exp 0003", drop_count); else pass_cnt++;
        repeat (65531) @(posedge clk);
        #3;
        total_cnt++; if (drop_count !== 16'hFFFE) $display("FAIL drop_fffe got %h exp fffe", drop_count); else pass_cnt++;
        repeat (5) @(posedge clk);
        #3;
        total_cnt++; if (drop_count !== 16'hFFFF) $display("FAIL drop_saturate got %h exp ffff", drop_count); else pass_cnt++;
        err_drop = 1'b0;
        rst = 1'b1;
        tick();
        total_cnt++; if (drop_count !== 16'h0) $display("FAIL drop_reset got %h exp 0000", drop_count); else pass_cnt++;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; lnk_up = 1'b0; buf_av = 6'd8; cfg_req = 1'b0; err_drop = 1'b0;
        tx_bus.tready = 1'b1;
        test_reset();
        lnk_up = 1'b1;
        test_single_port();
        test_round_robin();
        test_cfg();
        test_buf_av();
        test_link_drop();
        test_drop_counter();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
